multicycle_control: RTL

Main control FSM for the multi-cycle MIPS datapath. It sequences fetch, decode, execute, memory and write-back for each instruction. It drives the 2-bit `ALUOp` consumed by `alu_control`, plus every datapath enable and mux select. Memory accesses wait on a `mem_ready` handshake, so the FSM tolerates multi-cycle memory.

---
 rtl/multicycle_control.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_control.sv
// Main control FSM for the multi-cycle MIPS datapath (fetch/decode/execute/mem/wb).
// Define MC_ADDI_EN to build the addi states (ADDI_EX/ADDI_WB) and accept opcode 001000.
module multicycle_control (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       MemtoReg,
  output logic       IRWrite,
  output logic       ALUSrcA,
  output logic       RegWrite,
  output logic       RegDst,
  output logic [1:0] PCSource,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [3:0] state,
  output logic       illegal_op
);

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    FETCH    = 4'd1,
    DECODE   = 4'd2,
    MEMADR   = 4'd3,
    MEMRD    = 4'd4,
    MEMWB    = 4'd5,
    MEMWR    = 4'd6,
    RTYPE_EX = 4'd7,
    RTYPE_WB = 4'd8,
    BEQ      = 4'd9,
    JUMP     = 4'd10,
    ADDI_EX  = 4'd11,
    ADDI_WB  = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  typedef struct packed {
    logic       pcwrite;
    logic       pcwritecond;
    logic       iord;
    logic       memread;
    logic       memwrite;
    logic       memtoreg;
    logic       alusrca;
    logic       regwrite;
    logic       regdst;
    logic [1:0] pcsource;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic       fetch;
    logic       decode;
  } ctrl_t;

  state_t cur;
  state_t nxt;
  ctrl_t  ctrl;
  logic   legal;

  // Control word for a state; loaded into the output register alongside the state
  function automatic ctrl_t decode_state(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      FETCH: begin
        c.memread = 1'b1;
        c.alusrcb = 2'b01;
        c.fetch   = 1'b1;
      end
      DECODE: begin
        c.alusrcb = 2'b11;
        c.decode  = 1'b1;
      end
      MEMADR: begin
        c.alusrca = 1'b1;
        c.alusrcb = 2'b10;
      end
      MEMRD: begin
        c.memread = 1'b1;
        c.iord    = 1'b1;
      end
      MEMWB: begin
        c.memtoreg = 1'b1;
        c.regwrite = 1'b1;
      end
      MEMWR: begin
        c.memwrite = 1'b1;
        c.iord     = 1'b1;
      end
      RTYPE_EX: begin
        c.alusrca = 1'b1;
        c.aluop   = 2'b10;
      end
      RTYPE_WB: begin
        c.regdst   = 1'b1;
        c.regwrite = 1'b1;
      end
      BEQ: begin
        c.alusrca     = 1'b1;
        c.aluop       = 2'b01;
        c.pcwritecond = 1'b1;
        c.pcsource    = 2'b01;
      end
      JUMP: begin
        c.pcwrite  = 1'b1;
        c.pcsource = 2'b10;
      end
`ifdef MC_ADDI_EN
      ADDI_EX: begin
        c.alusrca = 1'b1;
        c.alusrcb = 2'b10;
      end
      ADDI_WB: begin
        c.regwrite = 1'b1;
      end
`endif
      default: ;
    endcase
    return c;
  endfunction

  always_comb begin
    legal = 1'b0;
    case (opcode)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J: legal = 1'b1;
`ifdef MC_ADDI_EN
      OP_ADDI: legal = 1'b1;
`endif
      default: legal = 1'b0;
    endcase
  end

  // Next-state logic; unbuilt or unused encodings fall back to FETCH
  always_comb begin
    nxt = FETCH;
    case (cur)
      IDLE:     nxt = FETCH;
      FETCH:    nxt = mem_ready ? DECODE : FETCH;
      DECODE: begin
        case (opcode)
          OP_RTYPE:     nxt = RTYPE_EX;
          OP_LW, OP_SW: nxt = MEMADR;
          OP_BEQ:       nxt = BEQ;
          OP_J:         nxt = JUMP;
`ifdef MC_ADDI_EN
          OP_ADDI:      nxt = ADDI_EX;
`endif
          default:      nxt = FETCH;
        endcase
      end
      MEMADR:   nxt = (opcode == OP_LW) ? MEMRD : MEMWR;
      MEMRD:    nxt = mem_ready ? MEMWB : MEMRD;
      MEMWB:    nxt = FETCH;
      MEMWR:    nxt = mem_ready ? FETCH : MEMWR;
      RTYPE_EX: nxt = RTYPE_WB;
      RTYPE_WB: nxt = FETCH;
      BEQ:      nxt = FETCH;
      JUMP:     nxt = FETCH;
`ifdef MC_ADDI_EN
      ADDI_EX:  nxt = ADDI_WB;
      ADDI_WB:  nxt = FETCH;
`endif
      default:  nxt = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cur  <= IDLE;
      ctrl <= '0;
    end else begin
      cur  <= nxt;
      ctrl <= decode_state(nxt);
    end
  end

  // Only the fetch write strobes and the illegal flag depend on live inputs
  assign IRWrite     = ctrl.fetch & mem_ready;
  assign PCWrite     = ctrl.pcwrite | (ctrl.fetch & mem_ready);
  assign illegal_op  = ctrl.decode & ~legal;
  assign PCWriteCond = ctrl.pcwritecond;
  assign IorD        = ctrl.iord;
  assign MemRead     = ctrl.memread;
  assign MemWrite    = ctrl.memwrite;
  assign MemtoReg    = ctrl.memtoreg;
  assign ALUSrcA     = ctrl.alusrca;
  assign RegWrite    = ctrl.regwrite;
  assign RegDst      = ctrl.regdst;
  assign PCSource    = ctrl.pcsource;
  assign ALUSrcB     = ctrl.alusrcb;
  assign ALUOp       = ctrl.aluop;
  assign state       = cur;

endmodule
